// File: rtl/axi_rom_slave_if.sv
// AXI4 bus bundle between an AXI master and the boot ROM slave.
// Write channels exist only to be handshaken and refused; read channels carry ROM data.
interface axi_rom_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [LEN_W-1:0]    ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_rom_slave.sv
// AXI4 read-only slave over a synchronous ROM; writes are drained and answered SLVERR.
// Latency: first RVALID one cycle after AR handshake, then one beat per cycle.
// Backpressure: RREADY low holds the ROM address so RDATA stays stable; no beat skipped.
module axi_rom_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ROM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    axi_rom_slave_if.slave    bus,
    input  logic [DATA_W-1:0] ROM_out,
    output logic              ROM_read,
    output logic              ROM_enable,
    output logic [ROM_AW-1:0] ROM_address
);
    localparam int         OFF_W    = $clog2(DATA_W / 8);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;   // address of the beat currently presented
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              err;    // whole burst is answered SLVERR
    } rd_ctx_t;

    typedef enum logic {R_IDLE, R_BEAT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic bad_req(input logic [LEN_W-1:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
        return (burst == 2'b11) || (size > MAX_SIZE) || ((burst == BURST_WRAP) && !wrap_ok);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input rd_ctx_t c);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << c.size;
        mask = ((ADDR_W'(c.len) + ADDR_W'(1)) << c.size) - ADDR_W'(1);
        case (c.burst)
            BURST_FIXED: return c.addr;
            BURST_WRAP:  return (c.addr & ~mask) | ((c.addr + step) & mask);
            default:     return c.addr + step;
        endcase
    endfunction

    function automatic logic [1:0] beat_resp(input logic err, input logic [ADDR_W-1:0] a);
        if (err)
            return RESP_SLVERR;
        else if ((a >> (ROM_AW + OFF_W)) != '0)
            return RESP_DECERR;
        else
            return RESP_OKAY;
    endfunction

    function automatic logic [ROM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return ROM_AW'(a >> OFF_W);
    endfunction

    // ---------------- read path ----------------
    r_state_t          r_state;
    rd_ctx_t           ctx;
    logic [LEN_W-1:0]  cnt;
    logic              ar_rdy;
    logic              r_vld;
    logic              r_last;
    logic [1:0]        r_resp;
    logic [ADDR_W-1:0] nxt_addr;
    logic              ar_fire;
    logic              ar_bad;

    assign nxt_addr = next_addr(ctx);
    assign ar_fire  = bus.ARVALID && ar_rdy;
    assign ar_bad   = bad_req(bus.ARLEN, bus.ARSIZE, bus.ARBURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            ctx     <= '0;
            cnt     <= '0;
            ar_rdy  <= 1'b0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_resp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_rdy <= 1'b1;
                    if (ar_fire) begin
                        ctx.id    <= bus.ARID;
                        ctx.addr  <= bus.ARADDR;
                        ctx.len   <= bus.ARLEN;
                        ctx.size  <= bus.ARSIZE;
                        ctx.burst <= bus.ARBURST;
                        ctx.err   <= ar_bad;
                        cnt       <= '0;
                        ar_rdy    <= 1'b0;
                        r_vld     <= 1'b1;
                        r_last    <= (bus.ARLEN == '0);
                        r_resp    <= beat_resp(ar_bad, bus.ARADDR);
                        r_state   <= R_BEAT;
                    end
                end
                R_BEAT: begin
                    if (bus.RREADY) begin
                        if (r_last) begin
                            r_vld   <= 1'b0;
                            r_last  <= 1'b0;
                            ar_rdy  <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            ctx.addr <= nxt_addr;
                            r_resp   <= beat_resp(ctx.err, nxt_addr);
                            r_last   <= (LEN_W'(cnt + 1'b1) == ctx.len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // The ROM has one cycle of latency, so the address for the following beat is
    // issued in the same cycle the current beat is accepted.
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;

    always_comb begin
        rom_en   = 1'b0;
        rom_addr = '0;
        if (r_state == R_BEAT) begin
            rom_en   = 1'b1;
            rom_addr = bus.RREADY ? word_idx(nxt_addr) : word_idx(ctx.addr);
        end else if (ar_fire) begin
            rom_en   = 1'b1;
            rom_addr = word_idx(bus.ARADDR);
        end
    end

    assign ROM_enable  = rom_en;
    assign ROM_read    = rom_en;
    assign ROM_address = rom_addr;

    assign bus.ARREADY = ar_rdy;
    assign bus.RVALID  = r_vld;
    assign bus.RID     = ctx.id;
    assign bus.RLAST   = r_last;
    assign bus.RRESP   = r_resp;
    assign bus.RDATA   = (r_vld && (r_resp == RESP_OKAY)) ? ROM_out : '0;

    // ---------------- write path ----------------
    w_state_t        w_state;
    logic            aw_rdy;
    logic            w_rdy;
    logic            b_vld;
    logic [1:0]      b_resp;
    logic [ID_W-1:0] b_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_rdy  <= 1'b0;
            w_rdy   <= 1'b0;
            b_vld   <= 1'b0;
            b_resp  <= RESP_OKAY;
            b_id    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_rdy <= 1'b1;
                    if (bus.AWVALID && aw_rdy) begin
                        b_id    <= bus.AWID;
                        aw_rdy  <= 1'b0;
                        w_rdy   <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.WVALID && w_rdy && bus.WLAST) begin
                        w_rdy   <= 1'b0;
                        b_vld   <= 1'b1;
                        b_resp  <= RESP_SLVERR;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        b_vld   <= 1'b0;
                        aw_rdy  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign bus.AWREADY = aw_rdy;
    assign bus.WREADY  = w_rdy;
    assign bus.BVALID  = b_vld;
    assign bus.BRESP   = b_resp;
    assign bus.BID     = b_id;

    // Write address attributes and payload are intentionally discarded.
    logic unused_wr;
    assign unused_wr = ^{bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.WDATA, bus.WSTRB};
endmodule
